riscv_iterative_alu: RTL and testbench
======================================

RISCV_ITERATIVE_ALU -- requirements
Module: riscv_iterative_alu

Interface
REQ-001 The block SHALL have one parameter: XLEN, default 32, datapath width; only 32 is supported.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, request to begin an operation.
REQ-006 The block SHALL have port ALUctrl, input, 4, operation code {func7 bit, func3} from the ALU control unit.
REQ-007 The block SHALL have port a, input, XLEN, operand A (rs1).
REQ-008 The block SHALL have port b, input, XLEN, operand B (rs2 or immediate).
REQ-009 The block SHALL have port busy, output, 1, operation in progress.
REQ-010 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 The block SHALL have port result, output, XLEN, registered result.
REQ-012 The block SHALL have port zero, output, 1, registered flag set when result == 0.

Function
REQ-013 The block SHALL decode ALUctrl as follows: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT (signed), 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.
REQ-014 The block SHALL treat any other ALUctrl code as illegal, producing result 0, zero 1 and latency 1.
REQ-015 The block SHALL implement two states: IDLE and SHIFT.
REQ-016 In IDLE, start=1 at edge N SHALL capture a, b[4:0] and ALUctrl, set busy=1, and ignore later changes on those inputs.
REQ-017 Non-shift operations SHALL be computed at edge N+1: result, zero and done=1 update, busy=0, and the state stays IDLE.
REQ-018 Shift operations (SLL/SRL/SRA) SHALL go to SHIFT with count = shamt = b[4:0] and shift one bit per edge, decrementing count.
REQ-019 When count reaches 0, the next edge SHALL write result and zero, pulse done, clear busy and return to IDLE.
REQ-020 Total latency L SHALL be 1 + shamt cycles, so done rises at edge N+L; shamt 0 gives L = 1.
REQ-021 SRA SHALL replicate bit 31 on each shift step; SRL and SLL SHALL shift in zeros.
REQ-022 ADD and SUB SHALL be modulo 2^32, with no carry or overflow output.
REQ-023 SLT and SLTU SHALL produce 32'h1 or 32'h0.
REQ-024 done SHALL be high for exactly one cycle per accepted start.
REQ-025 result and zero SHALL hold their values until the next completion.
REQ-026 start while busy=1 SHALL be ignored, with no queuing and no effect on the operation in flight.
REQ-027 start in the same cycle as done=1 SHALL be accepted, giving back-to-back operation with no bubble.
REQ-028 busy and done SHALL never be high in the same cycle.

Reset
REQ-029 While rst=1 the block SHALL immediately drive state IDLE, busy 0, done 0, result 0, zero 1, and clear the internal count.
REQ-030 rst asserted mid-operation SHALL abort the operation with no done pulse; result SHALL read 0 after reset.
REQ-031 start SHALL be ignored while rst=1; the first start accepted is on the first rising edge with rst=0.

Verification
REQ-032 The bench SHALL cover ADD: a=5, b=7, start at edge N -> done=1 and busy=0 after edge N+1, result=12, zero=0.
REQ-033 The bench SHALL cover SUB: a=32'h10, b=32'h10 -> result=0, zero=1, latency 1.
REQ-034 The bench SHALL cover SRA: a=32'h80000000, b=4 -> busy high edges N..N+4, done after edge N+5, result=32'hF8000000.
REQ-035 The bench SHALL cover SLT vs SLTU: a=32'hFFFFFFFF, b=1 -> SLT result=1 and SLTU result=0; back-to-back start on the done cycle is accepted.
REQ-036 The bench SHALL cover start while busy: SLL a=1, b=31, with a second start (ADD) at N+3 -> ignored, single done at N+32, result=32'h80000000.
REQ-037 The bench SHALL cover reset mid-shift: SRL, b=20, rst at N+5 -> busy=0, result=0, zero=1 immediately, and no done pulse afterwards.

Source files
------------

// File: rtl/riscv_iterative_alu.sv
// riscv_iterative_alu: RV32 ALU with single-cycle logic ops and one-bit-per-cycle shifts
module riscv_iterative_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      ALUctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [3:0] op, op_n;
  logic [XLEN-1:0] acc, acc_n, bv, bv_n, result_n, fin;
  logic [4:0] cnt, cnt_n;
  logic busy_n, done_n, zero_n, new_shift;
  function automatic logic [XLEN-1:0] alu(input logic [3:0] c, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    logic [XLEN-1:0] r;
    case (c)
      4'b0000: r = x + y;
      4'b1000: r = x - y;
      4'b0010: r = {{(XLEN-1){1'b0}}, $signed(x) < $signed(y)};
      4'b0011: r = {{(XLEN-1){1'b0}}, x < y};
      4'b0100: r = x ^ y;
      4'b0110: r = x | y;
      4'b0111: r = x & y;
      default: r = '0;
    endcase
    return r;
  endfunction
  assign new_shift = ALUctrl == 4'b0001 || ALUctrl == 4'b0101 || ALUctrl == 4'b1101;
  assign fin = state == SHIFT ? acc : alu(op, acc, bv);
  always_comb begin
    state_n  = state;
    op_n     = op;
    acc_n    = acc;
    bv_n     = bv;
    cnt_n    = cnt;
    busy_n   = busy;
    done_n   = 1'b0;
    result_n = result;
    zero_n   = zero;
    if (!busy && start) begin
      op_n    = ALUctrl;
      acc_n   = a;
      bv_n    = b;
      cnt_n   = new_shift ? b[4:0] : 5'd0;
      state_n = new_shift ? SHIFT : IDLE;
      busy_n  = 1'b1;
    end else if (busy && state == SHIFT && cnt != 5'd0) begin
      acc_n = op == 4'b0001 ? acc << 1 : {op == 4'b1101 && acc[XLEN-1], acc[XLEN-1:1]};
      cnt_n = cnt - 5'd1;
    end else if (busy) begin
      result_n = fin;
      zero_n   = fin == '0;
      done_n   = 1'b1;
      busy_n   = 1'b0;
      state_n  = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= IDLE;
      op     <= '0;
      acc    <= '0;
      bv     <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b1;
    end else begin
      state  <= state_n;
      op     <= op_n;
      acc    <= acc_n;
      bv     <= bv_n;
      cnt    <= cnt_n;
      busy   <= busy_n;
      done   <= done_n;
      result <= result_n;
      zero   <= zero_n;
    end
endmodule

// File: tb/tb_riscv_iterative_alu.sv
// tb_riscv_iterative_alu: directed and random checks of the iterative ALU against an arithmetic model
module tb_riscv_iterative_alu;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0] ALUctrl = '0;
  logic [31:0] a = '0, b = '0, result;
  logic busy, done, zero;
  int checks = 0, failures = 0;
  riscv_iterative_alu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .ALUctrl(ALUctrl), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] ref_res(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    case (c)
      4'd0:  return x + y;
      4'd8:  return x - y;
      4'd1:  return x << y[4:0];
      4'd2:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd3:  return (x < y) ? 32'd1 : 32'd0;
      4'd4:  return x ^ y;
      4'd5:  return x >> y[4:0];
      4'd13: return $signed(x) >>> y[4:0];
      4'd6:  return x | y;
      4'd7:  return x & y;
      default: return 32'd0;
    endcase
  endfunction
  function automatic int ref_lat(input logic [3:0] c, input logic [31:0] y);
    return (c == 4'd1 || c == 4'd5 || c == 4'd13) ? 1 + int'(y[4:0]) : 1;
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic do_op(input string tag, input logic [3:0] c, input logic [31:0] x, input logic [31:0] y, input bit b2b);
    logic [31:0] e;
    int l, n;
    e = ref_res(c, x, y);
    l = ref_lat(c, y);
    if (!b2b) @(negedge clk);
    ALUctrl = c; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; ALUctrl = 4'($urandom);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, l);
    check({tag, "_res"}, result, e);
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, e == 32'd0});
    check({tag, "_busydone"}, {31'd0, busy}, 32'd0);
  endtask
  initial begin
    int n, d;
    logic [3:0] codes [12] = '{4'd0, 4'd8, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd13, 4'd6, 4'd7, 4'd9, 4'd15};
    start = 1'b1;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    @(negedge clk); start = 1'b0; rst = 1'b0;
    do_op("add", 4'd0, 32'd5, 32'd7, 1'b0);
    do_op("sub", 4'd8, 32'h10, 32'h10, 1'b0);
    do_op("sra", 4'd13, 32'h80000000, 32'd4, 1'b0);
    do_op("slt", 4'd2, 32'hFFFFFFFF, 32'd1, 1'b0);
    do_op("sltu_b2b", 4'd3, 32'hFFFFFFFF, 32'd1, 1'b1);
    do_op("illegal", 4'd9, 32'h1234, 32'h5678, 1'b0);
    do_op("sll0", 4'd1, 32'hDEADBEEF, 32'd0, 1'b0);
    @(negedge clk);
    ALUctrl = 4'd1; a = 32'd1; b = 32'd31; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1; ALUctrl = 4'd0; a = 32'd5; b = 32'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 3;
    while (!done && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_start_lat", n, 32);
    check("busy_start_res", result, 32'h80000000);
    d = 0;
    repeat (5) begin
      @(posedge clk); #1;
      d += done;
    end
    check("busy_start_single_done", d, 0);
    check("busy_start_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    ALUctrl = 4'd5; a = 32'hF0F0F0F0; b = 32'd20; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1; rst = 1'b1; #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    check("rst_mid_zero", {31'd0, zero}, 32'd1);
    @(negedge clk); rst = 1'b0;
    d = 0;
    repeat (30) begin
      @(posedge clk); #1;
      d += done;
    end
    check("rst_mid_no_done", d, 0);
    for (int i = 0; i < 40; i++)
      do_op("rand", codes[$urandom_range(11)], $urandom, $urandom, i[0]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
